// File: rtl/aes_key_scheduler_if.sv
// Key-load handshake and round-key read port of the AES-128 key scheduler.
// master = key source / round controllers, slave = aes_key_scheduler.
interface aes_key_scheduler_if #(
    parameter int unsigned KW = 128
) ();
    logic          key_valid;
    logic [0:KW-1] key;
    logic          key_ready;
    logic [3:0]    rk_addr;
    logic [0:KW-1] round_key;
    logic          rk_valid;
    logic          busy;
    logic          done;

    modport master (
        output key_valid, key, rk_addr,
        input  key_ready, round_key, rk_valid, busy, done
    );

    modport slave (
        input  key_valid, key, rk_addr,
        output key_ready, round_key, rk_valid, busy, done
    );
endinterface

// File: rtl/aes_key_scheduler.sv
// Sequential AES-128 key schedule: one expansion round per clock, 11 round keys held for random-access reads.
// Optional KS_REUSE_EN: re-loading the key already held in slot0 while READY skips the expansion.
module aes_key_scheduler #(
    parameter int unsigned NR = 10,
    parameter int unsigned KW = 128
) (
    input  logic               clk,
    input  logic               rst,
    aes_key_scheduler_if.slave ks
);
    localparam int unsigned CTR_W = 4;
    localparam int unsigned NSLOT = NR + 1;

    // FIPS-197 S-box, byte i at bits [8*i +: 8]
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        logic [10:0] base;
        base = {b, 3'b000};
        return SBOX[base +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [CTR_W-1:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One key-expansion round; w0 is the leftmost word, byte 0 is the leftmost byte
    function automatic logic [0:KW-1] expand_round(input logic [0:KW-1] w, input logic [CTR_W-1:0] r);
        logic [0:31] w0, w1, w2, w3, rot, t;
        w0  = w[0:31];
        w1  = w[32:63];
        w2  = w[64:95];
        w3  = w[96:127];
        rot = {w3[8:31], w3[0:7]};
        t   = {sbox_byte(rot[0:7]), sbox_byte(rot[8:15]),
               sbox_byte(rot[16:23]), sbox_byte(rot[24:31])} ^ {rcon(r), 24'h000000};
        w0  = w0 ^ t;
        w1  = w1 ^ w0;
        w2  = w2 ^ w1;
        w3  = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t           state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [0:KW-1]    work_q;
    logic [0:KW-1]    slot_q [NSLOT];
    logic [0:KW-1]    next_key_c;
    logic [0:KW-1]    read_c;
    logic             key_ready_q, rk_valid_q, busy_q, done_q;
    logic [0:KW-1]    round_key_q;
    logic             accept_c, reuse_hit_c, start_c, last_c, done_d;

    assign accept_c = ks.key_valid && key_ready_q;
`ifdef KS_REUSE_EN
    assign reuse_hit_c = (state_q == ST_READY) && (ks.key == slot_q[0]);
`else
    assign reuse_hit_c = 1'b0;
`endif
    assign start_c    = accept_c && !reuse_hit_c;
    assign last_c     = (state_q == ST_EXPAND) && (ctr_q == CTR_W'(NR));
    assign next_key_c = expand_round(work_q, ctr_q);

    // Reads are hidden while invalid and on the edge that starts a fresh expansion
    assign read_c = (rk_valid_q && !start_c && (ks.rk_addr <= CTR_W'(NR))) ? slot_q[ks.rk_addr] : '0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = '0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d = ST_EXPAND;
                    ctr_d   = CTR_W'(1);
                end
            end
            ST_EXPAND: begin
                if (last_c) begin
                    state_d = ST_READY;
                    done_d  = 1'b1;
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end
            ST_READY: begin
                if (start_c) begin
                    state_d = ST_EXPAND;
                    ctr_d   = CTR_W'(1);
                end else if (accept_c) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q       <= '0;
            key_ready_q <= 1'b0;
            rk_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            round_key_q <= '0;
        end else begin
            ctr_q       <= ctr_d;
            key_ready_q <= (state_d != ST_EXPAND);
            rk_valid_q  <= (state_d == ST_READY);
            busy_q      <= (state_d == ST_EXPAND);
            done_q      <= done_d;
            round_key_q <= read_c;
        end
    end

    // Round-key storage; contents are masked by rk_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (start_c) begin
                slot_q[0] <= ks.key;
                work_q    <= ks.key;
            end else if (state_q == ST_EXPAND) begin
                slot_q[ctr_q] <= next_key_c;
                work_q        <= next_key_c;
            end
        end
    end

    assign ks.key_ready = key_ready_q;
    assign ks.rk_valid  = rk_valid_q;
    assign ks.busy      = busy_q;
    assign ks.done      = done_q;
    assign ks.round_key = round_key_q;
endmodule

// File: tb/tb_aes_key_scheduler.sv
// Self-checking bench for aes_key_scheduler: reference schedule built from GF(2^8) arithmetic.
module tb_aes_key_scheduler;
    logic clk;
    logic rst;

    aes_key_scheduler_if #(.KW(128)) ks_if ();

    aes_key_scheduler #(.NR(10), .KW(128)) dut (
        .clk (clk),
        .rst (rst),
        .ks  (ks_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [11];
    logic [127:0] model_key;
    logic         model_ready = 1'b0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box = affine transform of the multiplicative inverse in GF(2^8)
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox_m[v[31:24]], sbox_m[v[23:16]], sbox_m[v[15:8]], sbox_m[v[7:0]]};
    endfunction

    // Classic 44-word expansion w[i] = w[i-4] ^ g(w[i-1])
    task automatic compute_schedule(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic rd(input int a, output logic [127:0] v);
        ks_if.rk_addr = 4'(a);
        step();
        v = ks_if.round_key;
    endtask

    task automatic read_all();
        logic [127:0] v;
        for (int a = 0; a < 16; a++) begin
            rd(a, v);
            check($sformatf("rk_read[%0d]", a), v, (a <= 10) ? exp_rk[a] : 128'h0);
        end
    endtask

    task automatic read_random(input int n);
        logic [127:0] v;
        int           a;
        for (int i = 0; i < n; i++) begin
            a = int'($urandom_range(0, 15));
            rd(a, v);
            check($sformatf("rk_rand[%0d]", a), v, (a <= 10) ? exp_rk[a] : 128'h0);
        end
    endtask

    // mode 0: plain load, 1: foreign key pulsed in cycle 4, 2: reset in cycle 5
    task automatic run_key(input logic [127:0] k, input int mode);
        bit  reuse;
        bit  got_ready;
        got_ready = 1'b0;
        for (int i = 0; i < 20 && !got_ready; i++) begin
            if (ks_if.key_ready === 1'b1) got_ready = 1'b1;
            else step();
        end
        check("wait_key_ready", 128'(got_ready), 128'h1);
`ifdef KS_REUSE_EN
        reuse = model_ready && (k == model_key);
`else
        reuse = 1'b0;
`endif
        ks_if.key_valid = 1'b1;
        ks_if.key       = k;
        ks_if.rk_addr   = 4'd10;
        step();
        ks_if.key_valid = 1'b0;
        ks_if.key       = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (reuse) begin
            check("reuse_done", 128'(ks_if.done), 128'h1);
            check("reuse_busy", 128'(ks_if.busy), 128'h0);
            check("reuse_rk_valid", 128'(ks_if.rk_valid), 128'h1);
            step();
            check("reuse_done_pulse", 128'(ks_if.done), 128'h0);
            check("reuse_busy_after", 128'(ks_if.busy), 128'h0);
            return;
        end
        model_ready = 1'b0;
        compute_schedule(k);
        for (int e = 0; e < 10; e++) begin
            check($sformatf("exp_busy[%0d]", e), 128'(ks_if.busy), 128'h1);
            check($sformatf("exp_rk_valid[%0d]", e), 128'(ks_if.rk_valid), 128'h0);
            check($sformatf("exp_key_ready[%0d]", e), 128'(ks_if.key_ready), 128'h0);
            check($sformatf("exp_done_early[%0d]", e), 128'(ks_if.done), 128'h0);
            check($sformatf("exp_rk_hidden[%0d]", e), ks_if.round_key, 128'h0);
            if (mode == 1 && e == 3) begin
                ks_if.key_valid = 1'b1;
                ks_if.key       = ~k;
            end
            if (mode == 1 && e == 4) ks_if.key_valid = 1'b0;
            if (mode == 2 && e == 4) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check("rst_rk_valid", 128'(ks_if.rk_valid), 128'h0);
                check("rst_round_key", ks_if.round_key, 128'h0);
                check("rst_done", 128'(ks_if.done), 128'h0);
                check("rst_busy", 128'(ks_if.busy), 128'h0);
                check("rst_key_ready", 128'(ks_if.key_ready), 128'h0);
                for (int j = 0; j < 8; j++) begin
                    step();
                    check($sformatf("post_rst_done[%0d]", j), 128'(ks_if.done), 128'h0);
                    check($sformatf("post_rst_busy[%0d]", j), 128'(ks_if.busy), 128'h0);
                end
                check("post_rst_key_ready", 128'(ks_if.key_ready), 128'h1);
                return;
            end
            step();
        end
        check("done_at_10", 128'(ks_if.done), 128'h1);
        check("rk_valid_at_10", 128'(ks_if.rk_valid), 128'h1);
        check("busy_at_10", 128'(ks_if.busy), 128'h0);
        check("key_ready_at_10", 128'(ks_if.key_ready), 128'h1);
        step();
        check("done_pulse", 128'(ks_if.done), 128'h0);
        model_ready = 1'b1;
        model_key   = k;
    endtask

    logic [127:0] v;

    initial begin
        rst             = 1'b1;
        ks_if.key_valid = 1'b0;
        ks_if.key       = '0;
        ks_if.rk_addr   = '0;
        build_sbox();

        step();
        check("reset_key_ready", 128'(ks_if.key_ready), 128'h0);
        check("reset_rk_valid", 128'(ks_if.rk_valid), 128'h0);
        check("reset_busy", 128'(ks_if.busy), 128'h0);
        check("reset_done", 128'(ks_if.done), 128'h0);
        check("reset_round_key", ks_if.round_key, 128'h0);
        step();
        rst = 1'b0;
        step();
        check("idle_key_ready", 128'(ks_if.key_ready), 128'h1);
        check("idle_rk_valid", 128'(ks_if.rk_valid), 128'h0);

        run_key(FIPS_KEY, 0);
        rd(1, v);
        check("fips_rk1", v, FIPS_RK1);
        rd(10, v);
        check("fips_rk10", v, FIPS_RK10);
        rd(0, v);
        check("fips_rk0", v, FIPS_KEY);
        read_all();

        run_key(SEQ_KEY, 0);
        rd(10, v);
        check("seq_rk10", v, SEQ_RK10);
        read_all();

        run_key(SEQ_KEY, 0);
        check("after_reload_rk_valid", 128'(ks_if.rk_valid), 128'h1);
        read_all();

        run_key(FIPS_KEY, 1);
        rd(10, v);
        check("inject_rk10", v, FIPS_RK10);
        read_all();

        run_key({$urandom(), $urandom(), $urandom(), $urandom()}, 2);
        run_key(FIPS_KEY, 0);
        rd(1, v);
        check("reload_rk1", v, FIPS_RK1);
        read_random(6);

        ks_if.key_valid = 1'b1;
        ks_if.key       = {$urandom(), $urandom(), $urandom(), $urandom()};
        rst             = 1'b1;
        step();
        rst             = 1'b0;
        ks_if.key_valid = 1'b0;
        model_ready     = 1'b0;
        check("rst_prio_busy", 128'(ks_if.busy), 128'h0);
        check("rst_prio_rk_valid", 128'(ks_if.rk_valid), 128'h0);
        check("rst_prio_round_key", ks_if.round_key, 128'h0);
        step();
        check("rst_prio_busy2", 128'(ks_if.busy), 128'h0);
        check("rst_prio_key_ready", 128'(ks_if.key_ready), 128'h1);

        for (int i = 0; i < 4; i++) begin
            run_key({$urandom(), $urandom(), $urandom(), $urandom()}, 0);
            read_random(8);
        end
        run_key(model_key, 0);
        read_random(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_key_scheduler.md
# aes_key_scheduler

Sequential AES-128 key-schedule controller. Accepts a cipher key through a valid/ready handshake and iterates the one-round key-expansion function once per clock for rounds 1..10. It stores all 11 round keys in an internal register file. The encryption and decryption round controllers read round keys by index at any rate and in any order, so the block sits between key load and the round datapath.

## Interface
- `NR`, 10, number of rounds; only 10 (AES-128) is supported.
- `KW`, 128, key/round-key width; only 128 is supported.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `key_valid`  in  1  new key present on `key`.
- `key`  in  [0:127]  cipher key; byte 0 = `key[0:7]`.
- `key_ready`  out  1  block can accept a key.
- `rk_addr`  in  4  round-key index to read, 0..10.
- `round_key`  out  [0:127]  registered read data.
- `rk_valid`  out  1  all 11 round keys are valid for the current key.
- `busy`  out  1  expansion in progress.
- `done`  out  1  one-cycle pulse when the schedule completes.

## Operation
- FSM states and outputs:
  - IDLE: `key_ready`=1, `rk_valid`=0.
  - EXPAND: `key_ready`=0, `busy`=1.
  - READY: `key_ready`=1, `rk_valid`=1.
- Accept: `key_valid && key_ready` at an edge. On that edge:
  - slot0 <= `key`; work <= `key`.
  - round counter <= 1; `rk_valid` <= 0; state <= EXPAND.
- EXPAND, each cycle:
  - next = F(work, ctr); slot[ctr] <= next; work <= next; ctr <= ctr+1.
  - On the edge that writes slot10: state <= READY, `done` <= 1 for one cycle, `rk_valid` <= 1.
- F (4-bit ctr selects Rcon):
  - t = SubWord(RotWord(w3)) ^ {Rcon, 24'h0}, with Rcon = 01,02,04,08,10,20,40,80,1B,36 for ctr 1..10.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - w0 = bits [0:31] of the word, w3 = bits [96:127].
  - The S-box is the standard FIPS-197 table, held internally.
- `key_valid` during EXPAND is ignored; no queueing. The source holds the key until `key_ready`.
- READY accepts a new key and restarts the expansion (subject to Configuration).
- Read path:
  - `round_key` <= slot[`rk_addr`] on every edge.
  - Forced to 0 when `rk_valid`=0 or `rk_addr` > 10.

## Timing
- Reset values: state IDLE; `key_ready`=0 during the reset cycle and 1 afterwards; `rk_valid`=0, `busy`=0, `done`=0, `round_key`=0, counter=0.
- Slot contents need not be cleared; they are hidden by the forcing rule.
- Latency: key accepted at edge E0 → slot k written at edge Ek.
  - `done` and `rk_valid` go high after E10 (10 cycles).
  - `busy` is high from after E0 until E10.
- Read latency is 1 cycle: `rk_addr` sampled at edge E is seen on `round_key` after E.
- `rk_valid` falls on the accept edge, so no stale key is visible during re-expansion.
- `rst` asserted mid-EXPAND: the next edge returns to IDLE with all outputs at reset values. The partial schedule is discarded and no `done` pulse is produced.
- `rst` has priority over a simultaneous accept.
- The counter never exceeds 10; it holds at 0 outside EXPAND.

## Configuration
- `KS_REUSE_EN` defined:
  - In READY, an accepted key bitwise-equal to slot0 skips EXPAND.
  - State stays READY, `rk_valid` stays 1, `busy` stays 0, and `done` pulses on the cycle after accept.
- `KS_REUSE_EN` undefined: every accepted key runs the full 10-cycle EXPAND, and the 128-bit comparator is omitted.

## Test plan
- Full schedule: key 2b7e151628aed2a6abf7158809cf4f3c.
  - `done` pulses exactly 10 cycles after accept.
  - rk 1 = a0fafe1788542cb123a339392a6c7605.
  - rk 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Second key: key 000102030405060708090a0b0c0d0e0f accepted in READY → rk 10 = 13111d7fe3944a17f307a78b4d2b30c5; `rk_valid` is 0 during the 10 EXPAND cycles.
- Handshake: `key_valid` pulsed with a different key at cycle 4 of EXPAND.
  - That key is ignored and `key_ready` stays 0.
  - The original schedule completes unchanged.
- Reset mid-operation: `rst` at cycle 5 of EXPAND.
  - Next cycle: IDLE, `rk_valid`=0, `round_key`=0, no `done`.
  - A re-loaded key then completes normally.
- Read bounds: `rk_addr`=0 returns the key after 1 cycle; `rk_addr`=11..15 returns 0.
- Reuse (`KS_REUSE_EN`):
  - Re-accepting the same key in READY gives `done` after 1 cycle, `busy` never asserts, and `rk_valid` stays 1.
  - Without the macro, the same stimulus gives `done` after 10 cycles.
